// File: rtl/draw_game_objects_if.sv
// VGA timing/colour bundle shared by the pong pipeline stages.
interface vga_intf;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
    modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_game_objects.sv
// Ball-and-pads overlay: round ball plus two flashing pads, positions latched at vblank entry.
// Optional macro BALL_COLOR_CYCLE_EN: ball colour advances by COLOR_STEP every frame.
module draw_game_objects #(
    parameter int          BALL_SIZE    = 16,
    parameter int          PAD_HEIGHT   = 145,
    parameter int          PAD_WIDTH    = 15,
    parameter int          X_PAD_LEFT   = 30,
    parameter int          X_PAD_RIGHT  = 979,
    parameter logic [11:0] PAD_RGB      = 12'hFFF,
    parameter logic [11:0] FLASH_RGB    = 12'hF00,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [11:0] BALL_RGB     = 12'hFFF,
    parameter int          COLOR_STEP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] x_ball,
    input  logic [9:0]  y_ball,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    input  logic        hit_left,
    input  logic        hit_right,
    vga_intf.in         game_field_in,
    vga_intf.out        game_field_out
);

    localparam logic [11:0]        BALL_SIZE_W  = 12'(BALL_SIZE);
    localparam logic signed [7:0]  BALL_SIZE_S  = 8'(BALL_SIZE);
    localparam logic [15:0]        BALL_R2      = 16'(BALL_SIZE * BALL_SIZE);
    localparam logic [11:0]        PAD_HEIGHT_W = 12'(PAD_HEIGHT);
    localparam logic [11:0]        PAD_L_X0     = 12'(X_PAD_LEFT);
    localparam logic [11:0]        PAD_L_X1     = 12'(X_PAD_LEFT + PAD_WIDTH);
    localparam logic [11:0]        PAD_R_X0     = 12'(X_PAD_RIGHT);
    localparam logic [11:0]        PAD_R_X1     = 12'(X_PAD_RIGHT + PAD_WIDTH);
    localparam logic [7:0]         FLASH_LOAD   = 8'(FLASH_FRAMES);

    // A hit reloads the counter even when it coincides with a frame tick.
    function automatic logic [7:0] next_flash(input logic [7:0] cnt, input logic hit,
                                              input logic tick);
        logic [7:0] nxt;
        if (hit) begin
            nxt = FLASH_LOAD;
        end else if (tick && (cnt != 8'd0)) begin
            nxt = cnt - 8'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    logic        vblnk_prev_r;
    logic        frame_tick_s;
    logic [10:0] x_ball_r;
    logic [9:0]  y_ball_r;
    logic [9:0]  y_pad_left_r;
    logic [9:0]  y_pad_right_r;
    logic [7:0]  flash_left_r;
    logic [7:0]  flash_right_r;
    logic [11:0] ball_rgb_s;

    assign frame_tick_s = game_field_in.vblnk & ~vblnk_prev_r;

    // vblank edge detector, shadow positions and flash counters
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_r  <= 1'b1;
            x_ball_r      <= 11'd0;
            y_ball_r      <= 10'd0;
            y_pad_left_r  <= 10'd0;
            y_pad_right_r <= 10'd0;
            flash_left_r  <= 8'd0;
            flash_right_r <= 8'd0;
        end else begin
            vblnk_prev_r  <= game_field_in.vblnk;
            flash_left_r  <= next_flash(flash_left_r, hit_left, frame_tick_s);
            flash_right_r <= next_flash(flash_right_r, hit_right, frame_tick_s);
            if (frame_tick_s) begin
                x_ball_r      <= x_ball;
                y_ball_r      <= y_ball;
                y_pad_left_r  <= y_pad_left;
                y_pad_right_r <= y_pad_right;
            end
        end
    end

`ifdef BALL_COLOR_CYCLE_EN
    logic [11:0] ball_rgb_r;

    // per-frame ball colour cycle, wraps modulo 2^12
    always_ff @(posedge clk) begin
        if (rst) begin
            ball_rgb_r <= BALL_RGB;
        end else if (frame_tick_s) begin
            ball_rgb_r <= ball_rgb_r + 12'(COLOR_STEP);
        end
    end

    assign ball_rgb_s = ball_rgb_r;
`else
    assign ball_rgb_s = BALL_RGB;
`endif

    logic [11:0]       hc_s;
    logic [11:0]       vc_s;
    logic [11:0]       xb_s;
    logic [11:0]       yb_s;
    logic [11:0]       ypl_s;
    logic [11:0]       ypr_s;
    logic [5:0]        dx_s;
    logic [5:0]        dy_s;
    logic              box_s;
    logic              pad_left_s;
    logic              pad_right_s;
    logic signed [7:0] u_s;
    logic signed [7:0] v_s;

    // Zero-extended to 12 bits so box limits past the screen edge never wrap.
    assign hc_s  = {1'b0, game_field_in.hcount};
    assign vc_s  = {1'b0, game_field_in.vcount};
    assign xb_s  = {1'b0, x_ball_r};
    assign yb_s  = {2'b00, y_ball_r};
    assign ypl_s = {2'b00, y_pad_left_r};
    assign ypr_s = {2'b00, y_pad_right_r};

    assign box_s = (hc_s >= xb_s) && (hc_s < xb_s + BALL_SIZE_W) &&
                   (vc_s >= yb_s) && (vc_s < yb_s + BALL_SIZE_W);
    assign dx_s  = 6'(hc_s - xb_s);
    assign dy_s  = 6'(vc_s - yb_s);
    assign u_s   = $signed({1'b0, dx_s, 1'b1}) - BALL_SIZE_S;
    assign v_s   = $signed({1'b0, dy_s, 1'b1}) - BALL_SIZE_S;

    assign pad_left_s  = (hc_s >= PAD_L_X0) && (hc_s < PAD_L_X1) &&
                         (vc_s >= ypl_s) && (vc_s < ypl_s + PAD_HEIGHT_W);
    assign pad_right_s = (hc_s >= PAD_R_X0) && (hc_s < PAD_R_X1) &&
                         (vc_s >= ypr_s) && (vc_s < ypr_s + PAD_HEIGHT_W);

    logic [10:0]       hcount_1_r;
    logic [10:0]       vcount_1_r;
    logic              hsync_1_r;
    logic              vsync_1_r;
    logic              hblnk_1_r;
    logic              vblnk_1_r;
    logic [11:0]       rgb_1_r;
    logic              box_1_r;
    logic signed [7:0] u_1_r;
    logic signed [7:0] v_1_r;
    logic              pad_left_1_r;
    logic              pad_right_1_r;
    logic              flash_left_1_r;
    logic              flash_right_1_r;

    // stage 1: geometry compares and timing passthrough
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_1_r      <= 11'd0;
            vcount_1_r      <= 11'd0;
            hsync_1_r       <= 1'b0;
            vsync_1_r       <= 1'b0;
            hblnk_1_r       <= 1'b0;
            vblnk_1_r       <= 1'b0;
            rgb_1_r         <= 12'h000;
            box_1_r         <= 1'b0;
            u_1_r           <= 8'sd0;
            v_1_r           <= 8'sd0;
            pad_left_1_r    <= 1'b0;
            pad_right_1_r   <= 1'b0;
            flash_left_1_r  <= 1'b0;
            flash_right_1_r <= 1'b0;
        end else begin
            hcount_1_r      <= game_field_in.hcount;
            vcount_1_r      <= game_field_in.vcount;
            hsync_1_r       <= game_field_in.hsync;
            vsync_1_r       <= game_field_in.vsync;
            hblnk_1_r       <= game_field_in.hblnk;
            vblnk_1_r       <= game_field_in.vblnk;
            rgb_1_r         <= game_field_in.rgb;
            box_1_r         <= box_s;
            u_1_r           <= u_s;
            v_1_r           <= v_s;
            pad_left_1_r    <= pad_left_s;
            pad_right_1_r   <= pad_right_s;
            flash_left_1_r  <= (flash_left_r != 8'd0);
            flash_right_1_r <= (flash_right_r != 8'd0);
        end
    end

    logic [15:0] u_ext_s;
    logic [15:0] v_ext_s;
    logic [15:0] uu_s;
    logic [15:0] vv_s;
    logic [15:0] dist_s;
    logic        ball_on_s;
    logic [11:0] rgb_next_s;

    // Squares are non-negative and small, so the low 16 product bits are exact.
    assign u_ext_s   = {{8{u_1_r[7]}}, u_1_r};
    assign v_ext_s   = {{8{v_1_r[7]}}, v_1_r};
    assign uu_s      = u_ext_s * u_ext_s;
    assign vv_s      = v_ext_s * v_ext_s;
    assign dist_s    = uu_s + vv_s;
    assign ball_on_s = box_1_r && (dist_s <= BALL_R2);

    // colour priority: blanking, ball, pads, background
    always_comb begin
        rgb_next_s = 12'h000;
        if (hblnk_1_r || vblnk_1_r) begin
            rgb_next_s = 12'h000;
        end else if (ball_on_s) begin
            rgb_next_s = ball_rgb_s;
        end else if (pad_left_1_r) begin
            rgb_next_s = flash_left_1_r ? FLASH_RGB : PAD_RGB;
        end else if (pad_right_1_r) begin
            rgb_next_s = flash_right_1_r ? FLASH_RGB : PAD_RGB;
        end else begin
            rgb_next_s = rgb_1_r;
        end
    end

    // stage 2: registered output bundle
    always_ff @(posedge clk) begin
        if (rst) begin
            game_field_out.hcount <= 11'd0;
            game_field_out.vcount <= 11'd0;
            game_field_out.hsync  <= 1'b0;
            game_field_out.vsync  <= 1'b0;
            game_field_out.hblnk  <= 1'b0;
            game_field_out.vblnk  <= 1'b0;
            game_field_out.rgb    <= 12'h000;
        end else begin
            game_field_out.hcount <= hcount_1_r;
            game_field_out.vcount <= vcount_1_r;
            game_field_out.hsync  <= hsync_1_r;
            game_field_out.vsync  <= vsync_1_r;
            game_field_out.hblnk  <= hblnk_1_r;
            game_field_out.vblnk  <= vblnk_1_r;
            game_field_out.rgb    <= rgb_next_s;
        end
    end

endmodule
